// File: rtl/commit_trace_tx_if.sv
// Byte-stream link from the commit-trace transmitter to the host bridge.
//   out_valid : transmitter presents a trace byte
//   out_ready : host accepts the byte
//   out_data  : trace byte
// master = transmitter side, slave = host side.
interface commit_trace_tx_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/commit_trace_tx.sv
// commit_trace_tx: captures WB register writes and MEM stores, packs each one
// into a fixed-length record, queues records in a FIFO and streams them out
// byte by byte over a valid/ready link.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   trace_en            capture enable (queued records still drain when 0)
//   wb_*                write-back event (valid, pc, rd, data, is_load, addr)
//   st_*                store event (valid, pc, addr, data)
//   link (master)       out_valid / out_ready / out_data byte stream
//   drop_cnt            saturating count of dropped events
//   fifo_level          occupied record slots
//
// Record layout, byte 0 first: header {type[1:0], lost, rd[4:0]}, pc, addr,
// data, each 32-bit field little-endian (13 bytes).
// Optional build macro COMMIT_TRACE_TIMESTAMP_EN appends a 32-bit free-running
// cycle count captured with the event (17-byte records).
module commit_trace_tx #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trace_en,
    input  logic                    wb_valid,
    input  logic [31:0]             wb_pc,
    input  logic [4:0]              wb_rd,
    input  logic [31:0]             wb_data,
    input  logic                    wb_is_load,
    input  logic [31:0]             wb_addr,
    input  logic                    st_valid,
    input  logic [31:0]             st_pc,
    input  logic [31:0]             st_addr,
    input  logic [31:0]             st_data,
    commit_trace_tx_if.master       link,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned LVL_W  = AW + 1;
    localparam int unsigned CNT_W1 = CNT_W + 1;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    localparam int unsigned REC_BYTES = 17;
`else
    localparam int unsigned REC_BYTES = 13;
`endif
    localparam int unsigned REC_W = REC_BYTES * 8;
    localparam int unsigned SH_W  = REC_W - 8;
    localparam int unsigned IDX_W = $clog2(REC_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

    // Header sits in the low byte so the record shifts out LSB-first.
    typedef struct packed {
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [7:0]  header;
    } rec_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Storage and state
    rec_t               mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               lost_q;
    state_t             state;
    logic               out_valid_q;
    logic [7:0]         out_data_q;
    logic [SH_W-1:0]    shreg;
    logic [IDX_W-1:0]   idx;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0]        ts_q;
`endif

    // Capture-side combinational signals
    logic [LVL_W-1:0]   free_c;
    logic               wb_fire_c;
    logic               st_fire_c;
    logic               wb_push_c;
    logic               st_push_c;
    logic               lost_mid_c;
    logic               lost_d_c;
    logic [1:0]         n_drop_c;
    logic [CNT_W1-1:0]  drop_sum_c;
    logic [CNT_W-1:0]   drop_d_c;
    logic [LVL_W-1:0]   n_push_c;
    logic [AW-1:0]      st_slot_c;
    rec_t               wb_rec_c;
    rec_t               st_rec_c;

    // Serializer next-state signals
    state_t             state_d;
    logic               out_valid_d;
    logic [7:0]         out_data_d;
    logic [SH_W-1:0]    shreg_d;
    logic [IDX_W-1:0]   idx_d;
    logic               pop_c;
    logic [REC_W-1:0]   head_c;

    assign link.out_valid = out_valid_q;
    assign link.out_data  = out_data_q;

    // Admission, drop accounting and record formatting for this cycle's events.
    // Free space is taken from the registered level, so a same-cycle pop
    // never makes room for a push.
    always_comb begin
        free_c    = LVL_W'(DEPTH) - fifo_level;
        wb_fire_c = trace_en & wb_valid;
        st_fire_c = trace_en & st_valid;
        wb_push_c = wb_fire_c && (free_c != '0);
        st_push_c = st_fire_c && (free_c > LVL_W'(wb_push_c));

        // lost flag as seen by the store record, after the WB event is resolved
        if (wb_fire_c && !wb_push_c) begin
            lost_mid_c = 1'b1;
        end else if (wb_push_c) begin
            lost_mid_c = 1'b0;
        end else begin
            lost_mid_c = lost_q;
        end

        if (st_fire_c && !st_push_c) begin
            lost_d_c = 1'b1;
        end else if (st_push_c) begin
            lost_d_c = 1'b0;
        end else begin
            lost_d_c = lost_mid_c;
        end

        n_drop_c   = {1'b0, wb_fire_c & ~wb_push_c} + {1'b0, st_fire_c & ~st_push_c};
        drop_sum_c = {1'b0, drop_cnt} + CNT_W1'(n_drop_c);
        drop_d_c   = drop_sum_c[CNT_W] ? '1 : drop_sum_c[CNT_W-1:0];

        n_push_c  = LVL_W'(wb_push_c) + LVL_W'(st_push_c);
        st_slot_c = wb_push_c ? (wr_ptr + AW'(1)) : wr_ptr;

        wb_rec_c.header = {(wb_is_load ? 2'b11 : 2'b01), lost_q, wb_rd};
        wb_rec_c.pc     = wb_pc;
        wb_rec_c.addr   = wb_is_load ? wb_addr : 32'h0;
        wb_rec_c.data   = wb_data;

        st_rec_c.header = {2'b10, lost_mid_c, 5'd0};
        st_rec_c.pc     = st_pc;
        st_rec_c.addr   = st_addr;
        st_rec_c.data   = st_data;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        wb_rec_c.ts     = ts_q;
        st_rec_c.ts     = ts_q;
`endif
    end

    // Record storage; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (wb_push_c) begin
            mem[wr_ptr] <= wb_rec_c;
        end
        if (st_push_c) begin
            mem[st_slot_c] <= st_rec_c;
        end
    end

    // Serializer next-state and output logic
    always_comb begin
        state_d     = state;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        shreg_d     = shreg;
        idx_d       = idx;
        pop_c       = 1'b0;
        head_c      = mem[rd_ptr];

        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop_c       = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = head_c[7:0];
                    shreg_d     = head_c[REC_W-1:8];
                    idx_d       = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // out_valid is always high here, so ready alone is the handshake
                if (link.out_ready) begin
                    if (idx == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        idx_d      = idx + IDX_W'(1);
                        out_data_d = shreg[7:0];
                        shreg_d    = {8'h00, shreg[SH_W-1:8]};
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, pointers, counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            shreg       <= '0;
            idx         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            drop_cnt    <= '0;
            lost_q      <= 1'b0;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
            ts_q        <= 32'h0;
`endif
        end else begin
            state       <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            shreg       <= shreg_d;
            idx         <= idx_d;
            wr_ptr      <= wr_ptr + AW'(n_push_c);
            rd_ptr      <= rd_ptr + AW'(pop_c);
            fifo_level  <= fifo_level + n_push_c - LVL_W'(pop_c);
            drop_cnt    <= drop_d_c;
            lost_q      <= lost_d_c;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
            ts_q        <= ts_q + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_commit_trace_tx.sv
// Self-checking bench for commit_trace_tx: directed cases plus random traffic
// against a queue-based reference model; a monitor compares every output byte.
module tb_commit_trace_tx;

    localparam int DEPTH = 8;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    localparam int REC = 17;
`else
    localparam int REC = 13;
`endif

    logic        clk;
    logic        rst;
    logic        trace_en;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_is_load;
    logic [31:0] wb_addr;
    logic        st_valid;
    logic [31:0] st_pc;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [15:0] drop_cnt;
    logic [3:0]  fifo_level;
    logic [1:0]  drop_cnt2;
    logic [3:0]  fifo_level2;

    commit_trace_tx_if link ();
    commit_trace_tx_if link2 ();
    assign link2.out_ready = link.out_ready;

    commit_trace_tx #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_is_load(wb_is_load), .wb_addr(wb_addr),
        .st_valid(st_valid), .st_pc(st_pc), .st_addr(st_addr), .st_data(st_data),
        .link(link), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
    );

    // Narrow drop counter instance to exercise saturation
    commit_trace_tx #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .trace_en(trace_en),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_is_load(wb_is_load), .wb_addr(wb_addr),
        .st_valid(st_valid), .st_pc(st_pc), .st_addr(st_addr), .st_data(st_data),
        .link(link2), .drop_cnt(drop_cnt2), .fifo_level(fifo_level2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: records waiting in the FIFO, bytes left in the record
    // being sent, total drops, sticky lost flag, cycle counter, byte stream.
    int          m_lvl   = 0;
    int          m_left  = 0;
    int          m_drops = 0;
    bit          m_lost  = 0;
    logic [31:0] m_ts    = 0;
    logic [7:0]  exp_q [$];

    task automatic model_clear();
        m_lvl = 0; m_left = 0; m_drops = 0; m_lost = 0; m_ts = 0;
        exp_q.delete();
    endtask

    task automatic push_rec(input logic [1:0] typ, input bit lost, input logic [4:0] rd,
                            input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
        logic [7:0] hdr;
        hdr = {typ, lost, rd};
        exp_q.push_back(hdr);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(pc >> (8 * k)));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(addr >> (8 * k)));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(data >> (8 * k)));
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(m_ts >> (8 * k)));
`endif
    endtask

    // One clock edge of the model, using the inputs currently driven.
    task automatic model_step();
        bit pop;
        pop = (m_left == 0) && (m_lvl > 0);
        if (m_left > 0 && link.out_ready) m_left--;
        if (trace_en && wb_valid) begin
            if (m_lvl < DEPTH) begin
                push_rec(wb_is_load ? 2'b11 : 2'b01, m_lost, wb_rd, wb_pc,
                         wb_is_load ? wb_addr : 32'h0, wb_data);
                m_lost = 0;
                m_lvl++;
            end else begin
                m_drops++;
                m_lost = 1;
            end
        end
        if (trace_en && st_valid) begin
            if (m_lvl < DEPTH) begin
                push_rec(2'b10, m_lost, 5'd0, st_pc, st_addr, st_data);
                m_lost = 0;
                m_lvl++;
            end else begin
                m_drops++;
                m_lost = 1;
            end
        end
        m_ts = m_ts + 32'd1;
        if (pop) begin
            m_lvl--;
            m_left = REC;
        end
    endtask

    // Monitor: compare outputs mid-cycle, then advance the model for the next edge.
    always @(negedge clk) begin
        if (rst) begin
            check("out_valid", link.out_valid, m_left > 0);
            check("out_valid_cnt2", link2.out_valid, m_left > 0);
            if (m_left > 0 && exp_q.size() > 0) begin
                check("out_data", link.out_data, exp_q[0]);
                if (link.out_ready) void'(exp_q.pop_front());
            end
            check("fifo_level", fifo_level, m_lvl);
            check("fifo_level_cnt2", fifo_level2, m_lvl);
            check("drop_cnt", drop_cnt, (m_drops > 65535) ? 65535 : m_drops);
            check("drop_cnt_sat2", drop_cnt2, (m_drops > 3) ? 3 : m_drops);
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wb_valid = 0;
        st_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        quiet();
        link.out_ready = 1;
        while ((exp_q.size() > 0 || m_left > 0 || m_lvl > 0) && n < 1000) begin
            tick();
            n++;
        end
        check("drain_bytes_left", exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!link.out_valid && n < 100) begin
            tick();
            n++;
        end
        check(name, link.out_valid, 1);
    endtask

    task automatic set_wb(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] data,
                          input logic ld, input logic [31:0] addr);
        wb_valid = 1; wb_rd = rd; wb_pc = pc; wb_data = data; wb_is_load = ld; wb_addr = addr;
    endtask

    task automatic set_st(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1; st_pc = pc; st_addr = addr; st_data = data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; trace_en = 0; link.out_ready = 0;
        wb_valid = 0; wb_pc = 0; wb_rd = 0; wb_data = 0; wb_is_load = 0; wb_addr = 0;
        st_valid = 0; st_pc = 0; st_addr = 0; st_data = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1;
        check("rst_out_valid", link.out_valid, 0);
        check("rst_out_data", link.out_data, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_fifo_level", fifo_level, 0);
        trace_en = 1;
        link.out_ready = 1;
        tick();

        // Single register write: header 0x45 two edges after capture
        set_wb(5'd5, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h1234_5678);
        tick();
        quiet();
        check("t1_not_yet_valid", link.out_valid, 0);
        tick();
        check("t1_valid", link.out_valid, 1);
        check("t1_header", link.out_data, 8'h45);
        tick();
        check("t1_pc_b0", link.out_data, 8'h00);
        tick();
        check("t1_pc_b1", link.out_data, 8'h01);
        drain();

        // Load + same-cycle store: load record first, one bubble, then store
        set_wb(5'd3, 32'h0000_0100, 32'hCAFE_0001, 1, 32'h8000_0010);
        set_st(32'h0000_0104, 32'h0000_0020, 32'h0000_0011);
        tick();
        quiet();
        wait_valid("t2_valid");
        check("t2_load_header", link.out_data, 8'hC3);
        repeat (REC) tick();
        check("t2_bubble", link.out_valid, 0);
        tick();
        check("t2_store_valid", link.out_valid, 1);
        check("t2_store_header", link.out_data, 8'h80);
        drain();

        // Stall: fill FIFO behind a stalled record, WB fits / store drops, then a drop
        link.out_ready = 0;
        set_wb(5'd1, 32'h0000_0200, 32'h0000_0001, 0, 32'h0);
        tick();
        quiet();
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            set_wb(5'(i + 2), 32'h0000_0300 + 32'(4 * i), $urandom, 0, 32'h0);
            tick();
        end
        set_wb(5'd10, 32'h0000_0400, 32'h0000_00AA, 0, 32'h0);
        set_st(32'h0000_0404, 32'h0000_0040, 32'h0000_00BB);
        tick();
        quiet();
        set_wb(5'd11, 32'h0000_0408, 32'h0000_00CC, 0, 32'h0);
        tick();
        quiet();
        repeat (8) tick();
        check("t3_level_full", fifo_level, 8);
        check("t3_drop_cnt", drop_cnt, 2);
        check("t3_stalled_valid", link.out_valid, 1);
        check("t3_stalled_data", link.out_data, 8'h41);
        drain();
        set_wb(5'd9, 32'h0000_0500, 32'h0000_0009, 0, 32'h0);
        tick();
        quiet();
        wait_valid("t3_lost_valid");
        check("t3_lost_header", link.out_data, 8'h69);
        drain();

        // Reset in the middle of a record
        set_wb(5'd7, 32'h0000_0600, 32'h1111_2222, 0, 32'h0);
        tick();
        set_wb(5'd8, 32'h0000_0604, 32'h3333_4444, 0, 32'h0);
        tick();
        quiet();
        wait_valid("t4_valid");
        repeat (6) tick();
        #2 rst = 0;
        model_clear();
        #1;
        check("t4_async_valid_drop", link.out_valid, 0);
        check("t4_async_drop_cnt", drop_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        check("t4_level_after_reset", fifo_level, 0);
        repeat (20) tick();
        check("t4_no_residual", link.out_valid, 0);

        // Random traffic with random back-pressure and capture gating
        for (int c = 0; c < 3000; c++) begin
            trace_en       = ($urandom_range(0, 19) != 0);
            link.out_ready = ($urandom_range(0, 9) < 6);
            wb_valid       = ($urandom_range(0, 9) < 4);
            wb_rd          = 5'($urandom);
            wb_pc          = $urandom;
            wb_data        = $urandom;
            wb_is_load     = 1'($urandom);
            wb_addr        = $urandom;
            st_valid       = ($urandom_range(0, 9) < 3);
            st_pc          = $urandom;
            st_addr        = $urandom;
            st_data        = $urandom;
            tick();
        end
        trace_en = 1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
